// File: rtl/mem_bus_if.sv
// Bus bundle between the two caches, the arbiter and the single memory port.
// Handshake: a request is issued by driving a non-BUS_NONE command. It is taken only in the
// cycle where the returned accept tag (response) is non-zero. A zero response means rejected,
// and the requester retries with the same command on a later cycle. Return data is qualified
// only by a non-zero tag. There is no backpressure on returns.
interface mem_bus_if #(parameter int XLEN = 32);
  logic [1:0]      dc2arb_command;
  logic [XLEN-1:0] dc2arb_addr;
  logic [63:0]     dc2arb_data;
  logic [1:0]      ic2arb_command;
  logic [XLEN-1:0] ic2arb_addr;
  logic [3:0]      mem2arb_response;
  logic [63:0]     mem2arb_data;
  logic [3:0]      mem2arb_tag;
  logic [1:0]      arb2mem_command;
  logic [XLEN-1:0] arb2mem_addr;
  logic [63:0]     arb2mem_data;
  logic [3:0]      arb2dc_response;
  logic [63:0]     arb2dc_data;
  logic [3:0]      arb2dc_tag;
  logic [3:0]      arb2ic_response;
  logic [63:0]     arb2ic_data;
  logic [3:0]      arb2ic_tag;
  logic            orphan_err;
  logic [7:0]      starve_cnt;

  // Arbiter side
  modport slave (
    input  dc2arb_command, dc2arb_addr, dc2arb_data,
    input  ic2arb_command, ic2arb_addr,
    input  mem2arb_response, mem2arb_data, mem2arb_tag,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output arb2dc_response, arb2dc_data, arb2dc_tag,
    output arb2ic_response, arb2ic_data, arb2ic_tag,
    output orphan_err, starve_cnt
  );

  // Environment side: the caches and memory
  modport master (
    output dc2arb_command, dc2arb_addr, dc2arb_data,
    output ic2arb_command, ic2arb_addr,
    output mem2arb_response, mem2arb_data, mem2arb_tag,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  arb2dc_response, arb2dc_data, arb2dc_tag,
    input  arb2ic_response, arb2ic_data, arb2ic_tag,
    input  orphan_err, starve_cnt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-client memory port arbiter: dcache has priority, and icache gets a forced grant after
// STARVE_LIMIT consecutive losses. A tag->owner table steers returning data to the cache that
// issued the accepted request. Zero added latency in both directions.
module mem_bus_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 32
) (
  input logic      clock,
  input logic      reset,
  mem_bus_if.slave bus
);
  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [7:0] LIMIT8      = 8'(STARVE_LIMIT);

  logic [NUM_TAGS-1:0] tbl_valid;
  logic [NUM_TAGS-1:0] tbl_owner;    // 0 = dcache, 1 = icache
  logic [7:0]          starve_cnt;
  logic                orphan_err;

  logic dc_req, ic_req, dc_win, ic_win;
  logic ret_hit, ret_owner, accept;

  // Grant decision; the starvation counter only overrides dcache when icache is asking
  always_comb begin
    dc_req = bus.dc2arb_command != BUS_NONE;
    ic_req = bus.ic2arb_command != BUS_NONE;
    ic_win = ic_req && (!dc_req || starve_cnt == LIMIT8);
    dc_win = dc_req && !ic_win;
    accept = (dc_win || ic_win) && (bus.mem2arb_response != 4'd0);
  end

  // Request mux, response routing and return steering (table lookup sees pre-update contents)
  always_comb begin
    bus.arb2mem_command = BUS_NONE;
    bus.arb2mem_addr    = '0;
    bus.arb2mem_data    = '0;
    bus.arb2dc_response = 4'd0;
    bus.arb2ic_response = 4'd0;
    if (dc_win) begin
      bus.arb2mem_command = bus.dc2arb_command;
      bus.arb2mem_addr    = bus.dc2arb_addr;
      bus.arb2mem_data    = bus.dc2arb_data;
      bus.arb2dc_response = bus.mem2arb_response;
    end else if (ic_win) begin
      bus.arb2mem_command = bus.ic2arb_command;
      bus.arb2mem_addr    = bus.ic2arb_addr;
      bus.arb2ic_response = bus.mem2arb_response;
    end
    // Returns seen while reset is asserted belong to a forgotten epoch and are dropped
    ret_hit   = reset && (bus.mem2arb_tag != 4'd0) && tbl_valid[bus.mem2arb_tag];
    ret_owner = tbl_owner[bus.mem2arb_tag];
    bus.arb2dc_tag  = (ret_hit && !ret_owner) ? bus.mem2arb_tag : 4'd0;
    bus.arb2ic_tag  = (ret_hit &&  ret_owner) ? bus.mem2arb_tag : 4'd0;
    bus.arb2dc_data = bus.mem2arb_data;
    bus.arb2ic_data = bus.mem2arb_data;
    bus.orphan_err  = orphan_err;
    bus.starve_cnt  = starve_cnt;
  end

  // Owner table: a return frees its entry, an accept claims one; the later write wins on a tie
  always_ff @(posedge clock) begin
    if (!reset) begin
      tbl_valid <= '0;
      tbl_owner <= '0;
    end else begin
      if (bus.mem2arb_tag != 4'd0)
        tbl_valid[bus.mem2arb_tag] <= 1'b0;
      if (accept) begin
        tbl_valid[bus.mem2arb_response] <= 1'b1;
        tbl_owner[bus.mem2arb_response] <= ic_win;
      end
    end
  end

  // Sticky flag for a return tag that nobody is waiting on
  always_ff @(posedge clock) begin
    if (!reset)
      orphan_err <= 1'b0;
    else if ((bus.mem2arb_tag != 4'd0) && !tbl_valid[bus.mem2arb_tag])
      orphan_err <= 1'b1;
  end

  // Consecutive icache losses, saturating at the limit
  always_ff @(posedge clock) begin
    if (!reset)
      starve_cnt <= 8'd0;
    else if (ic_req && !ic_win)
      starve_cnt <= (starve_cnt < LIMIT8) ? starve_cnt + 8'd1 : starve_cnt;
    else
      starve_cnt <= 8'd0;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic, all checked
// against a tag-map reference model of the arbitration and routing rules.
module tb_mem_bus_arbiter;
  localparam int XLEN  = 32;
  localparam int LIMIT = 8;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clock;
  logic reset;
  mem_bus_if #(.XLEN(XLEN)) bus ();

  mem_bus_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit own_map[int];     // present = outstanding tag, value 1 = icache
  int losses   = 0;
  bit orphan_m = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver + model: apply one cycle of inputs, check outputs mid-cycle, then advance the model
  task automatic run_cycle(input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                           input logic [1:0] icc, input logic [31:0] ica,
                           input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    bit dc_req, ic_req, ic_win, dc_win, hit, hit_ic;
    bus.dc2arb_command   = dcc;
    bus.dc2arb_addr      = dca;
    bus.dc2arb_data      = dcd;
    bus.ic2arb_command   = icc;
    bus.ic2arb_addr      = ica;
    bus.mem2arb_response = resp;
    bus.mem2arb_tag      = rtag;
    bus.mem2arb_data     = rdata;
    dc_req = (dcc != NONE);
    ic_req = (icc != NONE);
    ic_win = ic_req && (!dc_req || losses == LIMIT);
    dc_win = dc_req && !ic_win;
    hit    = reset && rtag != 0 && own_map.exists(int'(rtag));
    hit_ic = hit && own_map[int'(rtag)];
    exp_q.push_back(64'(dc_win ? dcc : (ic_win ? icc : NONE)));
    exp_q.push_back(64'(dc_win ? dca : (ic_win ? ica : 32'd0)));
    exp_q.push_back(dc_win ? dcd : 64'd0);
    exp_q.push_back(64'(dc_win ? resp : 4'd0));
    exp_q.push_back(64'(ic_win ? resp : 4'd0));
    exp_q.push_back(64'((hit && !hit_ic) ? rtag : 4'd0));
    exp_q.push_back(64'(hit_ic ? rtag : 4'd0));
    exp_q.push_back(rdata);
    exp_q.push_back(rdata);
    exp_q.push_back(64'(orphan_m));
    exp_q.push_back(64'(losses));
    @(negedge clock);
    check_eq("mem_cmd",  64'(bus.arb2mem_command), exp_q.pop_front());
    check_eq("mem_addr", 64'(bus.arb2mem_addr),    exp_q.pop_front());
    check_eq("mem_data", bus.arb2mem_data,         exp_q.pop_front());
    check_eq("dc_resp",  64'(bus.arb2dc_response), exp_q.pop_front());
    check_eq("ic_resp",  64'(bus.arb2ic_response), exp_q.pop_front());
    check_eq("dc_tag",   64'(bus.arb2dc_tag),      exp_q.pop_front());
    check_eq("ic_tag",   64'(bus.arb2ic_tag),      exp_q.pop_front());
    check_eq("dc_data",  bus.arb2dc_data,          exp_q.pop_front());
    check_eq("ic_data",  bus.arb2ic_data,          exp_q.pop_front());
    check_eq("orphan",   64'(bus.orphan_err),      exp_q.pop_front());
    check_eq("starve",   64'(bus.starve_cnt),      exp_q.pop_front());
    @(posedge clock);
    if (!reset) begin
      own_map.delete();
      losses   = 0;
      orphan_m = 0;
    end else begin
      if (rtag != 0) begin
        if (own_map.exists(int'(rtag))) own_map.delete(int'(rtag));
        else orphan_m = 1;
      end
      if ((dc_win || ic_win) && resp != 0) own_map[int'(resp)] = ic_win;
      if (ic_req && !ic_win) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
      else losses = 0;
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] rtag, input logic [63:0] rdata);
    run_cycle(NONE, 32'd0, 64'd0, NONE, 32'd0, 4'd0, rtag, rdata);
  endtask

  initial begin
    int grant_cycle;
    int keys[$];
    logic [1:0] dcc, icc;
    logic [3:0] resp, rtag;

    // power-up reset, unchecked until state is defined
    reset = 1'b0;
    bus.dc2arb_command = NONE; bus.dc2arb_addr = '0; bus.dc2arb_data = '0;
    bus.ic2arb_command = NONE; bus.ic2arb_addr = '0;
    bus.mem2arb_response = '0; bus.mem2arb_tag = '0; bus.mem2arb_data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(4'd0, 64'd0);                          // reset state: orphan 0, counter 0

    // 1: single dcache load, later returned to dcache only
    run_cycle(LOAD, 32'h100, 64'd0, NONE, 32'd0, 4'd3, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    idle(4'd3, 64'hDEAD_BEEF_0000_0003);

    // 2: simultaneous loads, dcache wins, icache retries
    run_cycle(LOAD, 32'h200, 64'd0, LOAD, 32'h1000, 4'd5, 4'd0, 64'd0);
    run_cycle(NONE, 32'd0, 64'd0, LOAD, 32'h1000, 4'd6, 4'd0, 64'd0);
    idle(4'd5, 64'h55);
    idle(4'd6, 64'h66);

    // 3: continuous contention, icache forced through on the 9th cycle
    grant_cycle = 0;
    for (int i = 1; i <= 12; i++) begin
      run_cycle(STORE, 32'h300 + 32'(i * 8), 64'(i), LOAD, 32'h2000, 4'd0, 4'd0, 64'd0);
      if (grant_cycle == 0 && bus.starve_cnt == 8'd0) grant_cycle = i;
    end
    check_eq("starve_grant_cycle", 64'(grant_cycle), 64'd9);

    // 4: tag 4 returns to dcache while icache is accepted on tag 4
    run_cycle(LOAD, 32'h400, 64'd0, NONE, 32'd0, 4'd4, 4'd0, 64'd0);
    run_cycle(NONE, 32'd0, 64'd0, LOAD, 32'h3000, 4'd4, 4'd4, 64'h44);
    idle(4'd4, 64'h444);
    check_eq("tag4_ic_owner", 64'(bus.arb2ic_tag), 64'd0);   // entry now freed

    // 5: orphan return, sticky
    idle(4'd7, 64'h77);
    idle(4'd0, 64'd0);
    idle(4'd0, 64'd0);

    // 6: reset with outstanding tags, later return is an orphan
    run_cycle(STORE, 32'h500, 64'hAB, NONE, 32'd0, 4'd2, 4'd0, 64'd0);
    run_cycle(NONE, 32'd0, 64'd0, LOAD, 32'h4000, 4'd6, 4'd0, 64'd0);
    reset = 1'b0;
    idle(4'd0, 64'd0);
    reset = 1'b1;
    idle(4'd0, 64'd0);
    idle(4'd2, 64'h22);
    idle(4'd0, 64'd0);

    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      dcc  = 2'($urandom_range(0, 2));
      icc  = ($urandom_range(0, 1) == 1) ? LOAD : NONE;
      resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rtag = 4'd0;
      if ($urandom_range(0, 1) == 1) begin
        keys.delete();
        foreach (own_map[k]) keys.push_back(k);
        if (keys.size() > 0 && $urandom_range(0, 9) != 0)
          rtag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
        else
          rtag = 4'($urandom_range(1, 15));
      end
      run_cycle(dcc, $urandom() & 32'hFFFF_FFF8, {$urandom(), $urandom()},
                icc, $urandom(), resp, rtag, {$urandom(), $urandom()});
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
